barrel_shifter_32: RTL and testbench

Registered 32-bit barrel shifter for the integer execute datapath. It performs logical left, logical right and arithmetic right shifts by 0–31 positions using a single left-shift core. Right shifts are handled by bit-reversing the operand before the core and bit-reversing the result after it. One cycle of latency; the result feeds the ALU result mux.

---
 rtl/barrel_shifter_32_pkg.sv | 16 +
 rtl/barrel_shifter_32_if.sv | 25 ++
 rtl/barrel_shifter_32_bit_reverser.sv | 22 ++
 rtl/barrel_shifter_32.sv | 61 ++++++
 tb/tb_barrel_shifter_32.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/barrel_shifter_32_pkg.sv
// Shared constants and operation encoding for the integer shift datapath.
//   XLEN       : datapath width
//   SHAMT_W    : shift-amount width
//   shift_op_e : {right, sra} encoding for decode logic elsewhere
package shift_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [1:0] {
        SLL = 2'b00,
        SRL = 2'b10,
        SRA = 2'b11
    } shift_op_e;

endpackage

// File: rtl/barrel_shifter_32_if.sv
// Operand/result bundle for barrel_shifter_32.
//   in_valid, datain, shamt, right, sra : operation request (master -> slave)
//   dataout, out_valid                  : registered result (slave -> master)
interface barrel_shifter_32_if;
    import shift_pkg::*;

    logic               in_valid;
    logic [XLEN-1:0]    datain;
    logic [SHAMT_W-1:0] shamt;
    logic               right;
    logic               sra;
    logic [XLEN-1:0]    dataout;
    logic               out_valid;

    modport master (
        output in_valid, datain, shamt, right, sra,
        input  dataout, out_valid
    );

    modport slave (
        input  in_valid, datain, shamt, right, sra,
        output dataout, out_valid
    );

endinterface

// File: rtl/barrel_shifter_32_bit_reverser.sv
// Conditional bit reversal: mirrors the word when right=1, passes it otherwise.
//   right   : 1 = reverse bit order
//   datain  : input word
//   dataout : reversed or unchanged word (combinational)
module bit_reverser
    import shift_pkg::*;
(
    input  logic            right,
    input  logic [XLEN-1:0] datain,
    output logic [XLEN-1:0] dataout
);

    always_comb begin
        dataout = datain;
        if (right) begin
            for (int unsigned i = 0; i < XLEN; i++) begin
                dataout[i] = datain[XLEN-1-i];
            end
        end
    end

endmodule

// File: rtl/barrel_shifter_32.sv
// Registered 32-bit barrel shifter (SLL/SRL/SRA), one cycle latency.
// Right shifts reuse the left-shift core by mirroring operand and result.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of barrel_shifter_32_if (operands in, registered result out)
module barrel_shifter_32
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    barrel_shifter_32_if.slave bus
);

    logic [XLEN-1:0] rev_in;
    logic [XLEN-1:0] s16;
    logic [XLEN-1:0] s8;
    logic [XLEN-1:0] s4;
    logic [XLEN-1:0] s2;
    logic [XLEN-1:0] s1;
    logic [XLEN-1:0] result;
    logic            fill;

    bit_reverser u_rev_in (
        .right   (bus.right),
        .datain  (bus.datain),
        .dataout (rev_in)
    );

    // Sign fill only for arithmetic right shifts; it enters at the LSB of the
    // mirrored word, which becomes the MSB after the output mirror.
    assign fill = bus.right & bus.sra & bus.datain[XLEN-1];

    // Five-stage left-shift cascade: 16, 8, 4, 2, 1.
    always_comb begin
        s16 = bus.shamt[4] ? {rev_in[15:0], {16{fill}}} : rev_in;
        s8  = bus.shamt[3] ? {s16[23:0],    {8{fill}}}  : s16;
        s4  = bus.shamt[2] ? {s8[27:0],     {4{fill}}}  : s8;
        s2  = bus.shamt[1] ? {s4[29:0],     {2{fill}}}  : s4;
        s1  = bus.shamt[0] ? {s2[30:0],     fill}       : s2;
    end

    bit_reverser u_rev_out (
        .right   (bus.right),
        .datain  (s1),
        .dataout (result)
    );

    // Output register; dataout holds when no operation is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dataout   <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.dataout <= result;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter_32.sv
// Directed self-checking bench for barrel_shifter_32.
module tb_barrel_shifter_32;
    import shift_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    barrel_shifter_32_if bus ();

    barrel_shifter_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one request; caller advances the clock.
    task automatic set_op(input logic v, input logic [31:0] d, input int s,
                          input logic r, input logic a);
        bus.in_valid = v;
        bus.datain   = d;
        bus.shamt    = 5'(s);
        bus.right    = r;
        bus.sra      = a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_op(1'b0, 32'h0, 0, 1'b0, 1'b0);
        #3;
        n_cmp++;
        if (bus.dataout !== 32'h0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_init: dataout=%h out_valid=%b, want 00000000/0", bus.dataout, bus.out_valid);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.dataout !== 32'h0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: dataout=%h out_valid=%b, want 00000000/0", bus.dataout, bus.out_valid);
        end
    endtask

    task automatic test_srl_sweep();
        logic [31:0] exp;
        for (int s = 0; s < 32; s++) begin
            set_op(1'b1, 32'hFFFF_FFFF, s, 1'b1, 1'b0);
            exp = 32'hFFFF_FFFF >> s;
            @(posedge clk); #1;
            n_cmp++;
            if (bus.dataout !== exp || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL srl_sweep[%0d]: dataout=%h out_valid=%b, want %h/1", s, bus.dataout, bus.out_valid, exp);
            end
            if (s == 31) begin
                n_cmp++;
                if (bus.dataout !== 32'h0000_0001) begin
                    n_fail++;
                    $display("FAIL srl_31: dataout=%h, want 00000001", bus.dataout);
                end
            end
        end
    endtask

    task automatic test_sll_sweep();
        logic [31:0] exp;
        for (int s = 0; s < 32; s++) begin
            set_op(1'b1, 32'hFFFF_FFFF, s, 1'b0, 1'b0);
            exp = 32'hFFFF_FFFF << s;
            @(posedge clk); #1;
            n_cmp++;
            if (bus.dataout !== exp || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sll_sweep[%0d]: dataout=%h out_valid=%b, want %h/1", s, bus.dataout, bus.out_valid, exp);
            end
            if (s == 4) begin
                n_cmp++;
                if (bus.dataout !== 32'hFFFF_FFF0) begin
                    n_fail++;
                    $display("FAIL sll_4: dataout=%h, want fffffff0", bus.dataout);
                end
            end
            if (s == 31) begin
                n_cmp++;
                if (bus.dataout !== 32'h8000_0000) begin
                    n_fail++;
                    $display("FAIL sll_31: dataout=%h, want 80000000", bus.dataout);
                end
            end
        end
    endtask

    task automatic test_sra();
        logic [31:0] din [6];
        int          sh  [6];
        logic        rr  [6];
        logic        aa  [6];
        logic [31:0] exp [6];
        din = '{32'h8000_0000, 32'h8000_0000, 32'h7000_0000, 32'h8000_0000, 32'hF000_00FF, 32'h8765_4321};
        sh  = '{31, 4, 4, 1, 8, 0};
        rr  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        aa  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp = '{32'hFFFF_FFFF, 32'hF800_0000, 32'h0700_0000, 32'h0000_0000, 32'hFFF0_0000, 32'h8765_4321};
        for (int i = 0; i < 6; i++) begin
            set_op(1'b1, din[i], sh[i], rr[i], aa[i]);
            @(posedge clk); #1;
            n_cmp++;
            if (bus.dataout !== exp[i] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sra[%0d]: dataout=%h out_valid=%b, want %h/1", i, bus.dataout, bus.out_valid, exp[i]);
            end
        end
    endtask

    task automatic test_patterns();
        logic        rr  [5];
        logic        aa  [5];
        logic [31:0] din [5];
        int          sh  [5];
        logic [31:0] exp [5];
        rr  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        aa  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        din = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'hA5A5_0001, 32'hA5A5_0001};
        sh  = '{0, 0, 0, 16, 16};
        exp = '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h0001_0000, 32'h0000_A5A5};
        for (int i = 0; i < 5; i++) begin
            set_op(1'b1, din[i], sh[i], rr[i], aa[i]);
            @(posedge clk); #1;
            n_cmp++;
            if (bus.dataout !== exp[i]) begin
                n_fail++;
                $display("FAIL pattern[%0d]: dataout=%h, want %h", i, bus.dataout, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] din [3];
        int          sh  [3];
        logic        rr  [3];
        logic        aa  [3];
        logic [31:0] exp [3];
        din = '{32'h0000_00F0, 32'hF000_0000, 32'h8000_0010};
        sh  = '{4, 8, 4};
        rr  = '{1'b0, 1'b1, 1'b1};
        aa  = '{1'b0, 1'b0, 1'b1};
        exp = '{32'h0000_0F00, 32'h00F0_0000, 32'hF800_0001};
        for (int i = 0; i < 3; i++) begin
            set_op(1'b1, din[i], sh[i], rr[i], aa[i]);
            @(posedge clk); #1;
            n_cmp++;
            if (bus.dataout !== exp[i] || bus.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b[%0d]: dataout=%h out_valid=%b, want %h/1", i, bus.dataout, bus.out_valid, exp[i]);
            end
        end
        // Idle with different operands: output must hold the last result.
        set_op(1'b0, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (bus.dataout !== 32'hF800_0001 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: dataout=%h out_valid=%b, want f8000001/0", bus.dataout, bus.out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.dataout !== 32'hF800_0001 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_hold: dataout=%h out_valid=%b, want f8000001/0", bus.dataout, bus.out_valid);
        end
    endtask

    task automatic test_mid_reset();
        set_op(1'b1, 32'h0000_0003, 2, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (bus.dataout !== 32'h0000_000C || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset: dataout=%h out_valid=%b, want 0000000c/1", bus.dataout, bus.out_valid);
        end
        // Next operation in flight; reset lands between edges.
        set_op(1'b1, 32'h0000_0005, 1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (bus.dataout !== 32'h0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: dataout=%h out_valid=%b, want 00000000/0", bus.dataout, bus.out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.dataout !== 32'h0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: dataout=%h out_valid=%b, want 00000000/0", bus.dataout, bus.out_valid);
        end
        set_op(1'b1, 32'h0000_0001, 5, 1'b0, 1'b0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.dataout !== 32'h0000_0020 || bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: dataout=%h out_valid=%b, want 00000020/1", bus.dataout, bus.out_valid);
        end
        set_op(1'b0, 32'h0, 0, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.dataout !== 32'h0000_0020) begin
            n_fail++;
            $display("FAIL post_reset_idle: dataout=%h out_valid=%b, want 00000020/0", bus.dataout, bus.out_valid);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_srl_sweep();
        test_sll_sweep();
        test_sra();
        test_patterns();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
